mux4_scan_ctrl: RTL

MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/settle_timer.sv | 30 +++
 rtl/mux4_scan_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the 4:1 mux scan controller.
// State encoding, select and settle-count widths.
package mux_scan_pkg;

  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam sel_t LAST_CH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Settle-cycle down counter: load, decrement, zero flag.
// last flags that the next decrement reaches zero.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  cnt_t init,
  output logic zero,
  output logic last
);

  cnt_t cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= init;
    end else if (dec) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans a downstream 4:1 mux channel by channel and
// presents the captured word through a valid/ready handshake.
module mux4_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  state_t     state_q;
  state_t     state_d;
  sel_t       sel_q;
  logic [3:0] shadow_q;
  logic [3:0] data_q;
  logic       valid_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic tmr_last;

  logic st_idle;
  logic st_settle;
  logic st_sample;
  logic st_done;
  logic last_ch;

  assign st_idle   = (state_q == IDLE);
  assign st_settle = (state_q == SETTLE);
  assign st_sample = (state_q == SAMPLE);
  assign st_done   = (state_q == DONE);
  assign last_ch   = (sel_q == LAST_CH);

  settle_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .init (cnt_t'(SETTLE_CYC)),
    .zero (tmr_zero),
    .last (tmr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        if (tmr_last) state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = last_ch ? DONE : SETTLE;
      end
      DONE: begin
        if (ready) state_d = cont ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    busy     = 1'b1;
    unique case (1'b1)
      st_idle: begin
        tmr_load = start;
        busy     = 1'b0;
      end
      st_settle: begin
        tmr_dec = !tmr_zero;
      end
      st_sample: begin
        tmr_load = !last_ch;
      end
      st_done: begin
        tmr_load = ready && cont;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Select and capture registers follow the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        SAMPLE: begin
          shadow_q[sel_q] <= mux_out;
          if (last_ch) begin
            data_q  <= {mux_out, shadow_q[2:0]};
            valid_q <= 1'b1;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        DONE: begin
          if (ready) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
          end
        end
        default: begin
          valid_q <= valid_q;
        end
      endcase
    end
  end

  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign data  = data_q;
  assign valid = valid_q;

endmodule
